tt_um_dev_parity_tx: RTL and testbench
======================================

# tt_um_dev_parity_tx

Serial frame transmitter for the 3-bit odd-parity frame protocol. It accepts 2-bit data symbols through a valid/ready handshake and buffers them in a 4-entry FIFO. Each symbol is serialized as a 3-bit frame, two data bits followed by a parity bit, on a free-running 3-cycle frame grid. It is the sending end for the team's Mealy parity detector: `uo_out[0]` drives the detector's serial input, and a shared `rst_n` keeps both frame grids aligned.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Fixed at 4; the occupancy field is sized for 0..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  ignored
- `ui_in`  in  8:
  - [1:0] = `d`, data symbol
  - [2] = `valid`, push request
  - [3] = `err`, inject bad parity for this symbol
  - [4] = `tx_en`
  - [7:5] unused
- `uo_out`  out  8:
  - [0] = `tx_ser`
  - [1] = `frame_start`
  - [2] = `data_frame`
  - [3] = `ready`
  - [4] = `empty`
  - [7:5] = `count`, FIFO occupancy 0..4
- `uio_in`  in  8  unused
- `uio_out`  out  8  `frames_sent`, an 8-bit counter of data frames
- `uio_oe`  out  8  constant 8'hFF

## Operation
- **Reset** (asynchronous, takes effect immediately, also mid-frame):
  - `phase` = 0, FIFO cleared, shift register = 000, `frames_sent` = 0.
  - Outputs: `tx_ser` = 0, `frame_start` = 1, `data_frame` = 0, `ready` = 1, `empty` = 1, `count` = 0, `uio_out` = 0.
  - Any partially sent frame is dropped.
- **Frame grid**:
  - `phase` counts 0 → 1 → 2 → 0 continuously from reset release and never stalls.
  - `frame_start` = (`phase` == 0).
- **Push**:
  - Occurs on an edge where `valid` = 1 and `ready` = 1.
  - Writes {`err`, `d`} at the FIFO tail.
  - `valid` while full is ignored; the symbol is lost and no state changes.
  - `valid` is sampled as a level, so the upstream holds it for exactly one cycle per symbol.
- **Pop**:
  - Occurs on an edge where `phase` == 2, `tx_en` = 1 and the FIFO is non-empty, using pre-edge occupancy.
  - No write-through bypass: a symbol pushed on that same edge is not eligible.
  - Loads the shift register with frame bits b0 = `d[1]`, b1 = `d[0]`, b2 = `p`.
  - `p` = ~(`d[1]` ^ `d[0]`) for odd parity; `p` = `d[1]` ^ `d[0]` when the entry's `err` = 1.
  - Sets `data_frame` = 1 for the next 3 cycles and increments `frames_sent` (mod 256, 255 → 0).
- **Idle frame**:
  - Occurs on an edge where `phase` == 2 without a pop, either because the FIFO is empty or `tx_en` = 0.
  - Loads 000 (even parity, so the detector reports no hit) and sets `data_frame` = 0.
- **`tx_en`**:
  - Affects only pop decisions; a frame in flight always completes.
  - Pushes are accepted regardless of `tx_en`.
- **Simultaneous push and pop**:
  - Both happen on the same edge; `count` is unchanged.
  - Accepted only if the pre-edge state was not full.
- **FIFO**:
  - 2-bit read and write pointers wrap 3 → 0.
  - `count` is 3 bits.
  - `ready` = (`count` != 4); `empty` = (`count` == 0).
- **Registered outputs**: all outputs are registered or derived from registered state only; there is no combinational path from `ui_in` to `uo_out`.

## Timing
- `tx_ser` presents bit b[`phase`] of the current frame.
- A frame occupies the 3 cycles with `phase` = 0, 1, 2 after the load edge.
- **Push-to-first-bit latency**: b0 appears on the cycle after the first phase-2 edge strictly after the push edge.
  - Range 2..4 cycles with `tx_en` = 1 and an empty FIFO.
- **Back-to-back frames**: with the FIFO non-empty and `tx_en` = 1, frames are gapless at 3 cycles per symbol. Steady state is 1 symbol per 3 cycles.
- **Counter and occupancy**: `frames_sent` and `count` update on the load or push edge and are visible in the following cycle.

## Test plan
- **Reset values**: release reset with no input → `tx_ser` stays 0 for 30 cycles, `frame_start` pulses every 3rd cycle starting in the first cycle, `ready` = 1, `empty` = 1, `uio_out` = 0.
- **All four symbols**: push `d` = 00, 01, 10, 11 with `tx_en` = 1 → serial stream 001 010 100 111 in 4 consecutive frames; `data_frame` high for 12 cycles; `frames_sent` = 4; an attached detector pulses once per frame.
- **Error injection**: push `d` = 10 with `err` = 1 → frame 101; the detector reports no hit; `frames_sent` still increments.
- **Full FIFO and hold**: with `tx_en` = 0, push 5 symbols → `count` = 4, `ready` = 0, the 5th symbol is dropped. Then set `tx_en` = 1 → exactly 4 data frames are sent and `count` returns to 0.
- **Simultaneous events and wrap**:
  - Push on a phase-2 pop edge with `count` = 3 → `count` stays 3 and the FIFO pointers wrap correctly.
  - Stream 256 frames → `frames_sent` wraps to 0.
- **Reset mid-operation**: assert `rst_n` low during b1 of a data frame with 3 symbols queued → all outputs take their reset values immediately. After release, only idle 000 frames are sent and the grid restarts at `phase` 0.

Source files
------------

// File: rtl/tt_um_dev_parity_tx_if.sv
// Pin bundle of the parity frame transmitter: dedicated inputs/outputs plus the bidir bank.
// The transmitter takes the slave side, the upstream driver or bench takes the master side.
interface tt_um_dev_parity_tx_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_dev_parity_tx.sv
// Odd-parity 3-bit frame transmitter: a 4-entry symbol FIFO feeds a free-running 3-cycle frame grid.
// Frame phase FSM:
//   state | meaning
//   PH_B0 | frame bit b0 (d[1]) on tx_ser, frame_start high
//   PH_B1 | frame bit b1 (d[0]) on tx_ser
//   PH_B2 | parity bit on tx_ser; the edge leaving it loads the next frame
module tt_um_dev_parity_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tt_um_dev_parity_tx_if.slave     bus
);

    typedef enum logic [1:0] {
        PH_B0 = 2'd0,
        PH_B1 = 2'd1,
        PH_B2 = 2'd2
    } phase_t;

    localparam logic [2:0] FULL_COUNT = 3'(DEPTH);

    phase_t     phase;
    logic [2:0] fifo_mem [0:3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic [2:0] shreg;
    logic       data_frame;
    logic [7:0] frames_sent;

    logic [1:0] d;
    logic       valid;
    logic       err;
    logic       tx_en;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic [2:0] head;
    logic       head_par;
    logic       parity_bit;
    logic       tx_ser;
    logic       frame_start;
    logic       unused_pins;

    assign d     = bus.ui_in[1:0];
    assign valid = bus.ui_in[2];
    assign err   = bus.ui_in[3];
    assign tx_en = bus.ui_in[4];

    assign unused_pins = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:5]};

    assign full  = (count == FULL_COUNT);
    assign empty = (count == 3'd0);
    assign push  = valid && !full;
    // Pop eligibility uses pre-edge occupancy, so a same-edge push never bypasses the FIFO.
    assign pop   = (phase == PH_B2) && tx_en && !empty;

    assign head       = fifo_mem[rd_ptr];
    assign head_par   = head[1] ^ head[0];
    assign parity_bit = head[2] ? head_par : ~head_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= PH_B0;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 3'd0;
            shreg       <= 3'b000;
            data_frame  <= 1'b0;
            frames_sent <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 3'b000;
            end
        end else begin
            case (phase)
                PH_B0:   phase <= PH_B1;
                PH_B1:   phase <= PH_B2;
                PH_B2:   phase <= PH_B0;
                default: phase <= PH_B0;
            endcase

            if (push) begin
                fifo_mem[wr_ptr] <= {err, d};
                wr_ptr           <= wr_ptr + 2'd1;
            end

            if (pop) begin
                rd_ptr      <= rd_ptr + 2'd1;
                shreg       <= {parity_bit, head[0], head[1]};
                data_frame  <= 1'b1;
                frames_sent <= frames_sent + 8'd1;
            end else if (phase == PH_B2) begin
                // Idle frame 000 has even parity, so the downstream detector stays quiet.
                shreg      <= 3'b000;
                data_frame <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        tx_ser = 1'b0;
        case (phase)
            PH_B0:   tx_ser = shreg[0];
            PH_B1:   tx_ser = shreg[1];
            PH_B2:   tx_ser = shreg[2];
            default: tx_ser = 1'b0;
        endcase
    end

    assign frame_start = (phase == PH_B0);

    assign bus.uo_out  = {count, empty, !full, data_frame, frame_start, tx_ser};
    assign bus.uio_out = frames_sent;
    assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_dev_parity_tx.sv
// Directed bench for the parity frame transmitter: grid, framing, FIFO full/hold, wrap and reset.
module tb_tt_um_dev_parity_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] d;
    logic       valid;
    logic       err;
    logic       tx_en;

    int checks = 0;
    int errors = 0;
    int ph = 0;
    int cyc = 0;
    int ndata = 0;
    int first_data = -1;
    int last_data = -1;
    int nfr = 0;
    logic [35:0] cap;
    logic [11:0] exp12;

    tt_um_dev_parity_tx_if bus ();

    assign bus.ena    = 1'b1;
    assign bus.uio_in = 8'h00;
    assign bus.ui_in  = {3'b000, tx_en, err, valid, d};

    tt_um_dev_parity_tx #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire       tx_ser      = bus.uo_out[0];
    wire       frame_start = bus.uo_out[1];
    wire       data_frame  = bus.uo_out[2];
    wire       ready       = bus.uo_out[3];
    wire       empty_o     = bus.uo_out[4];
    wire [2:0] count_o     = bus.uo_out[7:5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        cap = '0;
        ndata = 0;
        first_data = -1;
        last_data = -1;
    endtask

    // Advance one cycle, sample at the falling edge, check the grid and capture data bits.
    task automatic tick();
        @(negedge clk);
        ph = (ph + 1) % 3;
        cyc++;
        chk("grid_frame_start", 32'(frame_start), 32'(ph == 0));
        if (data_frame) begin
            if ((ndata % 3) == 0) chk("frame_align", 32'(ph), 32'd0);
            cap = {cap[34:0], tx_ser};
            ndata++;
            if (first_data < 0) first_data = cyc;
            last_data = cyc;
        end else begin
            chk("idle_tx_ser", 32'(tx_ser), 32'd0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ph = 0;
        cyc = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        d = 2'b00;
        valid = 1'b0;
        err = 1'b0;
        tx_en = 1'b0;
        clear_cap();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_uo_out", 32'(bus.uo_out), 32'h1A);
        chk("rst_uio_out", 32'(bus.uio_out), 32'h00);
        chk("uio_oe", 32'(bus.uio_oe), 32'hFF);

        release_reset();
        chk("rel_frame_start", 32'(frame_start), 32'd1);
        chk("rel_uo_out", 32'(bus.uo_out), 32'h1A);
        repeat (30) tick();
        chk("idle_ndata", 32'(ndata), 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_empty", 32'(empty_o), 32'd1);
        chk("idle_frames", 32'(bus.uio_out), 32'd0);

        // All four symbols, tx_en high
        tx_en = 1'b1;
        clear_cap();
        valid = 1'b1;
        d = 2'b00; tick();
        d = 2'b01; tick();
        d = 2'b10; tick();
        d = 2'b11; tick();
        valid = 1'b0;
        repeat (14) tick();
        exp12 = 12'b001_010_100_111;
        chk("four_ndata", 32'(ndata), 32'd12);
        chk("four_gapless", 32'(last_data - first_data + 1), 32'd12);
        chk("four_stream", 32'(cap[11:0]), 32'(exp12));
        chk("four_frames", 32'(bus.uio_out), 32'd4);
        chk("four_empty", 32'(empty_o), 32'd1);

        // Error injection: 10 with bad parity -> 101
        clear_cap();
        valid = 1'b1; err = 1'b1; d = 2'b10;
        tick();
        valid = 1'b0; err = 1'b0;
        repeat (8) tick();
        chk("err_ndata", 32'(ndata), 32'd3);
        chk("err_frame", 32'(cap[2:0]), 32'b101);
        chk("err_frames", 32'(bus.uio_out), 32'd5);

        // Full FIFO with tx_en low, fifth symbol dropped
        tx_en = 1'b0;
        tick();
        clear_cap();
        valid = 1'b1;
        d = 2'b01; tick();
        d = 2'b10; tick();
        d = 2'b11; tick();
        chk("fill3_count", 32'(count_o), 32'd3);
        d = 2'b00; tick();
        d = 2'b01; tick();
        valid = 1'b0;
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(ready), 32'd0);
        chk("full_empty", 32'(empty_o), 32'd0);
        repeat (4) tick();
        chk("hold_ndata", 32'(ndata), 32'd0);
        chk("hold_count", 32'(count_o), 32'd4);
        tx_en = 1'b1;
        repeat (20) tick();
        exp12 = 12'b010_100_111_001;
        chk("drain_ndata", 32'(ndata), 32'd12);
        chk("drain_gapless", 32'(last_data - first_data + 1), 32'd12);
        chk("drain_stream", 32'(cap[11:0]), 32'(exp12));
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_ready", 32'(ready), 32'd1);
        chk("drain_frames", 32'(bus.uio_out), 32'd9);

        // Push on a pop edge with count 3; write pointer wraps 3 -> 0
        tx_en = 1'b0;
        clear_cap();
        valid = 1'b1;
        d = 2'b11; err = 1'b0; tick();
        d = 2'b01; err = 1'b1; tick();
        d = 2'b10; err = 1'b0; tick();
        valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ph == 2) break;
            tick();
        end
        chk("sim_pre_phase", 32'(ph), 32'd2);
        chk("sim_pre_count", 32'(count_o), 32'd3);
        valid = 1'b1; d = 2'b00; tx_en = 1'b1;
        tick();
        valid = 1'b0;
        chk("sim_count", 32'(count_o), 32'd3);
        chk("sim_data_frame", 32'(data_frame), 32'd1);
        repeat (14) tick();
        exp12 = 12'b111_011_100_001;
        chk("sim_ndata", 32'(ndata), 32'd12);
        chk("sim_gapless", 32'(last_data - first_data + 1), 32'd12);
        chk("sim_stream", 32'(cap[11:0]), 32'(exp12));
        chk("sim_count_end", 32'(count_o), 32'd0);
        chk("sim_frames", 32'(bus.uio_out), 32'd13);

        // Stream until frames_sent wraps 255 -> 0
        clear_cap();
        nfr = 0;
        d = 2'b00; err = 1'b0; valid = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            tick();
            if (data_frame && frame_start) begin
                nfr++;
                if (nfr == 242) chk("wrap_255", 32'(bus.uio_out), 32'd255);
            end
            if (nfr == 243) break;
        end
        valid = 1'b0;
        tx_en = 1'b0;
        chk("wrap_reached", 32'(nfr), 32'd243);
        chk("wrap_zero", 32'(bus.uio_out), 32'd0);
        tick();
        chk("stop_count", 32'(count_o), 32'd3);

        // Reset during b1 of a data frame with 3 symbols queued
        valid = 1'b1; d = 2'b01;
        tick();
        valid = 1'b0;
        chk("pre_rst_full", 32'(count_o), 32'd4);
        chk("pre_rst_ready", 32'(ready), 32'd0);
        tx_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (data_frame && frame_start) break;
            tick();
        end
        chk("pre_rst_start", 32'(data_frame && frame_start), 32'd1);
        tick();
        chk("pre_rst_b1_phase", 32'(ph), 32'd1);
        chk("pre_rst_b1_count", 32'(count_o), 32'd3);
        chk("pre_rst_b1_df", 32'(data_frame), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_uo_out", 32'(bus.uo_out), 32'h1A);
        chk("mid_rst_uio_out", 32'(bus.uio_out), 32'd0);
        repeat (2) @(negedge clk);
        chk("hold_rst_uo_out", 32'(bus.uo_out), 32'h1A);
        release_reset();
        clear_cap();
        chk("post_rst_start", 32'(frame_start), 32'd1);
        repeat (15) tick();
        chk("post_rst_ndata", 32'(ndata), 32'd0);
        chk("post_rst_empty", 32'(empty_o), 32'd1);
        chk("post_rst_frames", 32'(bus.uio_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
